game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level game-phase controller for the space invaders design. It sequences attract, play, player-hit, level-clear and game-over phases. It converts the per-frame tick into gated update strobes for the player, bullet and invader datapaths, and sets invader march speed by level. It sits between the debouncer and the entity/score datapaths, on the system clock.

Parameters:
HIT_FRAMES, 90, frames frozen after player is hit
CLEAR_FRAMES, 120, frames paused between levels
BASE_PERIOD, 32, frames between invader march steps at level 0
PERIOD_STEP, 4, march-period reduction per level
MIN_PERIOD, 4, lower clamp on march period

Ports:
clk  in  1  system clock (100 MHz)
arst  in  1  asynchronous reset, active-low
frame_tick  in  1  one-cycle pulse per video frame
shoot  in  1  debounced shoot pulse
player_collision  in  1  one-cycle pulse: player hit
invaders_cleared  in  1  level: zero invaders alive
invaders_landed  in  1  level: an invader reached player row
lives  in  2  remaining lives from score_logic
state  out  3  0=IDLE 1=PLAY 2=HIT 3=CLEAR 4=OVER
update_en  out  1  one-cycle strobe: advance player/bullets this frame
march_tick  out  1  one-cycle strobe: step invader formation
game_rst  out  1  one-cycle pulse: clear score/lives and respawn all
level_rst  out  1  one-cycle pulse: respawn invaders and bullets, keep score
score_en  out  1  high only in PLAY; gates score_logic collision inputs
level  out  3  current level, saturating at 7

Behaviour:
- Reset (arst low, asynchronous): state=IDLE, level=0, all counters 0. All strobes/pulses are 0 and score_en=0.
- All outputs are registered. A strobe asserts the cycle after its qualifying input cycle and lasts exactly one cycle.
- IDLE: on shoot, pulse game_rst, set level=0, clear the march counter, go to PLAY.
- PLAY:
  - score_en=1.
  - On frame_tick, update_en pulses and march_cnt increments.
  - When march_cnt+1 >= march_period on a frame_tick, march_tick pulses with that update_en and march_cnt clears.
  - march_period = max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_STEP), computed in 6 bits with no underflow (clamp before subtract).
  - Exit priority when several conditions hold in the same cycle:
    - invaders_landed -> OVER.
    - player_collision -> HIT, wait counter=0.
    - invaders_cleared -> CLEAR, wait counter=0.
  - When an exit is taken, no update_en or march_tick is generated that cycle, even if frame_tick is coincident.
- HIT:
  - No update_en or march_tick; score_en=0.
  - Wait counter increments on frame_tick.
  - At HIT_FRAMES: if lives==0, go to OVER; else pulse level_rst and go to PLAY with march_cnt=0.
  - lives is sampled at expiry, so the decrement made by score_logic on the hit cycle is already visible.
- CLEAR:
  - Frozen as in HIT.
  - At CLEAR_FRAMES: level = min(level+1, 7), pulse level_rst, clear march_cnt, go to PLAY.
- OVER:
  - Frozen; level is held for display.
  - On shoot, behave as from IDLE (game_rst, level=0, PLAY).
- shoot in PLAY, HIT or CLEAR is ignored by this block; bullet spawning is gated by update_en downstream.
- player_collision or invaders_cleared outside PLAY is ignored.
- Wait counter is 8 bits, large enough for both frame parameters.
- arst assertion mid-phase returns the block to IDLE immediately, with no pulses emitted.

Test Plan:
- Reset release, then shoot pulse -> game_rst high for 1 cycle, state=PLAY, level=0. After 32 frame_ticks, exactly 32 update_en and 1 march_tick.
- Force level=7 through 7 clears -> march_period=4 (32-28); a further clear keeps level=7 and period=4. Also check MIN_PERIOD clamp with PERIOD_STEP=8 (level 4 -> 4, not underflow).
- player_collision with lives=2 -> HIT, no update_en for 90 frames, then level_rst pulse and PLAY. Repeat with lives=0 at expiry -> OVER, no level_rst.
- invaders_landed, player_collision and invaders_cleared in the same cycle as frame_tick -> OVER, no update_en or march_tick that cycle.
- invaders_cleared at level 0 -> CLEAR for 120 frames, then level=1, level_rst, march period=28.
- arst asserted mid-HIT -> state=IDLE asynchronously, all outputs 0. shoot in OVER -> game_rst, level=0, PLAY.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-phase controller: sequences attract/play/hit/clear/over phases and turns the
// per-frame tick into gated player/bullet update and invader march strobes.
module game_sequencer #(
  parameter int HIT_FRAMES   = 90,
  parameter int CLEAR_FRAMES = 120,
  parameter int BASE_PERIOD  = 32,
  parameter int PERIOD_STEP  = 4,
  parameter int MIN_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       frame_tick,
  input  logic       shoot,
  input  logic       player_collision,
  input  logic       invaders_cleared,
  input  logic       invaders_landed,
  input  logic [1:0] lives,
  output logic [2:0] state,
  output logic       update_en,
  output logic       march_tick,
  output logic       game_rst,
  output logic       level_rst,
  output logic       score_en,
  output logic [2:0] level
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_level;
  logic [7:0] r_wait_cnt;
  logic [5:0] r_march_cnt;
  logic       r_update_en;
  logic       r_march_tick;
  logic       r_game_rst;
  logic       r_level_rst;
  logic       r_score_en;

  state_t     w_state_nxt;
  logic [2:0] w_level_nxt;
  logic [7:0] w_wait_nxt;
  logic [5:0] w_march_nxt;
  logic       w_update_en;
  logic       w_march_tick;
  logic       w_game_rst;
  logic       w_level_rst;
  logic [5:0] w_dec;
  logic [5:0] w_period;
  logic [5:0] w_march_inc;
  logic [7:0] w_wait_inc;

  assign w_dec       = 6'(r_level) * 6'(PERIOD_STEP);
  assign w_march_inc = r_march_cnt + 6'd1;
  assign w_wait_inc  = r_wait_cnt + 8'd1;

  // March period: clamp is decided before subtracting so the 6-bit value never wraps.
  always_comb begin
    w_period = 6'(MIN_PERIOD);
    if (w_dec >= 6'(BASE_PERIOD - MIN_PERIOD)) begin
      w_period = 6'(MIN_PERIOD);
    end else begin
      w_period = 6'(BASE_PERIOD) - w_dec;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_wait_nxt   = r_wait_cnt;
    w_march_nxt  = r_march_cnt;
    w_update_en  = 1'b0;
    w_march_tick = 1'b0;
    w_game_rst   = 1'b0;
    w_level_rst  = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (shoot) begin
          w_game_rst  = 1'b1;
          w_level_nxt = 3'd0;
          w_march_nxt = 6'd0;
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PLAY: begin
        // Any exit suppresses this cycle's strobes, even with a coincident frame tick.
        if (invaders_landed) begin
          w_state_nxt = ST_OVER;
        end else if (player_collision) begin
          w_state_nxt = ST_HIT;
          w_wait_nxt  = 8'd0;
        end else if (invaders_cleared) begin
          w_state_nxt = ST_CLEAR;
          w_wait_nxt  = 8'd0;
        end else if (frame_tick) begin
          w_update_en = 1'b1;
          if (w_march_inc >= w_period) begin
            w_march_tick = 1'b1;
            w_march_nxt  = 6'd0;
          end else begin
            w_march_nxt = w_march_inc;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_HIT: begin
        if (frame_tick && (w_wait_inc >= 8'(HIT_FRAMES))) begin
          w_wait_nxt = 8'd0;
          if (lives == 2'd0) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_level_rst = 1'b1;
            w_march_nxt = 6'd0;
            w_state_nxt = ST_PLAY;
          end
        end else if (frame_tick) begin
          w_wait_nxt = w_wait_inc;
        end else begin
          w_state_nxt = ST_HIT;
        end
      end
      ST_CLEAR: begin
        if (frame_tick && (w_wait_inc >= 8'(CLEAR_FRAMES))) begin
          w_wait_nxt  = 8'd0;
          w_level_nxt = (r_level == 3'd7) ? 3'd7 : (r_level + 3'd1);
          w_level_rst = 1'b1;
          w_march_nxt = 6'd0;
          w_state_nxt = ST_PLAY;
        end else if (frame_tick) begin
          w_wait_nxt = w_wait_inc;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state      <= ST_IDLE;
      r_level      <= 3'd0;
      r_wait_cnt   <= 8'd0;
      r_march_cnt  <= 6'd0;
      r_update_en  <= 1'b0;
      r_march_tick <= 1'b0;
      r_game_rst   <= 1'b0;
      r_level_rst  <= 1'b0;
      r_score_en   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_march_cnt  <= w_march_nxt;
      r_update_en  <= w_update_en;
      r_march_tick <= w_march_tick;
      r_game_rst   <= w_game_rst;
      r_level_rst  <= w_level_rst;
      r_score_en   <= (w_state_nxt == ST_PLAY);
    end
  end

  assign state      = r_state;
  assign level      = r_level;
  assign update_en  = r_update_en;
  assign march_tick = r_march_tick;
  assign game_rst   = r_game_rst;
  assign level_rst  = r_level_rst;
  assign score_en   = r_score_en;

endmodule
